// File: rtl/jpeg_packetizer_if.sv
// ---------------------------------------------------------------------------
// jpeg_packetizer_if
// Purpose : bundles the encoder-side byte stream and the packet-side
//           valid/ready byte stream of jpeg_packetizer.
// Signals : in_valid/in_data          - push-only JPEG bytes from the encoder
//           out_valid/out_ready       - packet byte handshake
//           out_data/out_sop/out_eop  - packet byte with start/end markers
//           drop_pulse                - one cycle per discarded frame tail
//           frame_id                  - id of the frame being ingested
// Modports: master - the packetizer (consumes in_*, drives out_*)
//           slave  - its environment (drives in_*, consumes out_*)
// ---------------------------------------------------------------------------
interface jpeg_packetizer_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_sop;
  logic       out_eop;
  logic       drop_pulse;
  logic [7:0] frame_id;

  modport master (
    input  in_valid, in_data, out_ready,
    output out_valid, out_data, out_sop, out_eop, drop_pulse, frame_id
  );

  modport slave (
    output in_valid, in_data, out_ready,
    input  out_valid, out_data, out_sop, out_eop, drop_pulse, frame_id
  );
endinterface

// File: rtl/jpeg_packetizer.sv
// ---------------------------------------------------------------------------
// jpeg_packetizer
// Purpose : splits the MJPEG encoder byte stream into packets of at most
//           PAYLOAD_MAX payload bytes, each preceded by a 6-byte header
//           (MAGIC, {last,7'b0}, frame_id, seq, len[15:8], len[7:0]).
//           Bytes are buffered in a 2^BUF_AW byte RAM; a 4-entry descriptor
//           FIFO hands closed packets to the egress FSM. On overflow the rest
//           of the frame is discarded up to its EOI marker (FF D9).
// Ports   : clk   - encoder clock
//           rst_n - asynchronous, active-low reset
//           bus   - jpeg_packetizer_if.master (ingress, egress, status)
// ---------------------------------------------------------------------------
module jpeg_packetizer #(
  parameter int unsigned PAYLOAD_MAX = 1024,
  parameter int unsigned BUF_AW      = 12,
  parameter logic [7:0]  MAGIC       = 8'h4A
) (
  input  logic              clk,
  input  logic              rst_n,
  jpeg_packetizer_if.master bus
);
  localparam int unsigned    DEPTH = 1 << BUF_AW;
  localparam int unsigned    PW    = BUF_AW + 1;   // pointer width incl. wrap bit
  localparam logic [PW-1:0]  P_ONE = PW'(1);
  localparam logic [15:0]    PMAX  = 16'(PAYLOAD_MAX);

  typedef struct packed {
    logic        last;
    logic [7:0]  fid;
    logic [7:0]  seq;
    logic [15:0] len;
  } desc_t;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAY} state_t;

  // ---------------- storage ----------------
  logic [7:0]    r_mem [DEPTH];
  logic [7:0]    r_mem_q;          // always holds r_mem[r_fetch_ptr]
  desc_t         r_dfifo [4];
  logic [2:0]    r_dwp, r_drp;

  // ---------------- ingress state ----------------
  logic [PW-1:0] r_wr_ptr, r_pkt_start;
  logic [15:0]   r_cur_len;
  logic [7:0]    r_prev, r_seq, r_fid;
  logic          r_discard, r_drop;

  // ---------------- egress state ----------------
  state_t        r_state;
  logic [2:0]    r_idx;
  desc_t         r_desc;
  logic [15:0]   r_pay_cnt;
  logic [PW-1:0] r_fetch_ptr, r_rel_ptr;
  logic          r_out_valid, r_out_sop, r_out_eop, r_out_pay;
  logic [7:0]    r_out_data;

  // ---------------- combinational ----------------
  logic          w_buf_full, w_fifo_empty, w_fifo_full, w_eoi;
  logic          w_load, w_pop, w_push, w_we, w_abandon, w_release;
  desc_t         w_fifo_head, w_push_desc;
  logic [15:0]   w_len_inc;
  logic [PW-1:0] w_wr_ptr_nxt, w_pkt_start_nxt, w_fetch_nxt;
  logic [15:0]   w_cur_len_nxt;
  logic [7:0]    w_prev_nxt, w_seq_nxt, w_fid_nxt;
  logic          w_discard_nxt, w_drop_nxt;
  state_t        w_state_nxt;
  logic [2:0]    w_idx_nxt;
  desc_t         w_desc_nxt;
  logic [15:0]   w_pay_cnt_nxt;
  logic          w_fetch_inc;
  logic          w_out_valid_nxt, w_out_sop_nxt, w_out_eop_nxt, w_out_pay_nxt;
  logic [7:0]    w_out_data_nxt;

  function automatic logic [7:0] hdr_byte(input desc_t d, input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = MAGIC;
      3'd1:    b = {d.last, 7'b0};
      3'd2:    b = d.fid;
      3'd3:    b = d.seq;
      3'd4:    b = d.len[15:8];
      default: b = d.len[7:0];
    endcase
    return b;
  endfunction

  // Occupancy is measured against the release pointer, which only moves when
  // a payload byte is actually accepted downstream.
  assign w_buf_full   = (r_wr_ptr[BUF_AW] != r_rel_ptr[BUF_AW]) &&
                        (r_wr_ptr[BUF_AW-1:0] == r_rel_ptr[BUF_AW-1:0]);
  assign w_fifo_empty = (r_dwp == r_drp);
  assign w_fifo_full  = (r_dwp[1:0] == r_drp[1:0]) && (r_dwp[2] != r_drp[2]);
  assign w_fifo_head  = r_dfifo[r_drp[1:0]];
  assign w_eoi        = bus.in_valid && (r_prev == 8'hFF) && (bus.in_data == 8'hD9);
  assign w_load       = !r_out_valid || bus.out_ready;   // output slot free this edge
  assign w_pop        = (r_state == S_IDLE) && w_load && !w_fifo_empty;
  assign w_release    = r_out_valid && bus.out_ready && r_out_pay;
  assign w_len_inc    = r_cur_len + 16'd1;

  // ---------------- ingress next-state ----------------
  always_comb begin
    w_wr_ptr_nxt    = r_wr_ptr;
    w_pkt_start_nxt = r_pkt_start;
    w_cur_len_nxt   = r_cur_len;
    w_prev_nxt      = r_prev;
    w_discard_nxt   = r_discard;
    w_seq_nxt       = r_seq;
    w_fid_nxt       = r_fid;
    w_drop_nxt      = 1'b0;
    w_we            = 1'b0;
    w_push          = 1'b0;
    w_push_desc     = '0;
    w_abandon       = 1'b0;
    if (bus.in_valid) begin
      // The previous byte is tracked even while discarding so the EOI that
      // ends a dropped tail is still recognised.
      w_prev_nxt = bus.in_data;
      if (r_discard || w_buf_full) begin
        if (w_eoi) w_abandon = 1'b1;
        else       w_discard_nxt = 1'b1;
      end else begin
        w_we          = 1'b1;
        w_wr_ptr_nxt  = r_wr_ptr + P_ONE;
        w_cur_len_nxt = w_len_inc;
        if (w_eoi || (w_len_inc == PMAX)) begin
          // A pop in the same cycle frees a slot, so a full FIFO can still
          // take the descriptor.
          if (!w_fifo_full || w_pop) begin
            w_push          = 1'b1;
            w_push_desc     = '{last: w_eoi, fid: r_fid, seq: r_seq, len: w_len_inc};
            w_pkt_start_nxt = r_wr_ptr + P_ONE;
            w_cur_len_nxt   = '0;
            if (w_eoi) begin
              w_seq_nxt = '0;
              w_fid_nxt = r_fid + 8'd1;
            end else begin
              w_seq_nxt = r_seq + 8'd1;
            end
          end else if (w_eoi) begin
            w_abandon = 1'b1;
          end else begin
            w_discard_nxt = 1'b1;
          end
        end
      end
    end
    // End of a corrupted frame: rewind over the uncommitted bytes.
    if (w_abandon) begin
      w_wr_ptr_nxt  = r_pkt_start;
      w_cur_len_nxt = '0;
      w_drop_nxt    = 1'b1;
      w_fid_nxt     = r_fid + 8'd1;
      w_seq_nxt     = '0;
      w_discard_nxt = 1'b0;
    end
  end

  // ---------------- egress FSM next-state / outputs ----------------
  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_desc_nxt      = r_desc;
    w_pay_cnt_nxt   = r_pay_cnt;
    w_fetch_inc     = 1'b0;
    w_out_valid_nxt = r_out_valid;
    w_out_data_nxt  = r_out_data;
    w_out_sop_nxt   = r_out_sop;
    w_out_eop_nxt   = r_out_eop;
    w_out_pay_nxt   = r_out_pay;
    if (w_load) begin
      case (r_state)
        S_IDLE: begin
          w_out_valid_nxt = 1'b0;
          w_out_data_nxt  = '0;
          w_out_sop_nxt   = 1'b0;
          w_out_eop_nxt   = 1'b0;
          w_out_pay_nxt   = 1'b0;
          if (!w_fifo_empty) begin
            // Popping and presenting header byte 0 in the same edge keeps
            // the close-to-valid latency at one cycle.
            w_desc_nxt      = w_fifo_head;
            w_out_valid_nxt = 1'b1;
            w_out_data_nxt  = hdr_byte(w_fifo_head, 3'd0);
            w_out_sop_nxt   = 1'b1;
            w_idx_nxt       = 3'd1;
            w_state_nxt     = S_HDR;
          end
        end
        S_HDR: begin
          w_out_valid_nxt = 1'b1;
          w_out_data_nxt  = hdr_byte(r_desc, r_idx);
          w_out_sop_nxt   = 1'b0;
          w_out_eop_nxt   = 1'b0;
          w_out_pay_nxt   = 1'b0;
          w_idx_nxt       = r_idx + 3'd1;
          if (r_idx == 3'd5) begin
            w_pay_cnt_nxt = '0;
            w_state_nxt   = S_PAY;
          end
        end
        S_PAY: begin
          w_out_valid_nxt = 1'b1;
          w_out_data_nxt  = r_mem_q;
          w_out_sop_nxt   = 1'b0;
          w_out_eop_nxt   = (r_pay_cnt == r_desc.len - 16'd1);
          w_out_pay_nxt   = 1'b1;
          w_fetch_inc     = 1'b1;
          w_pay_cnt_nxt   = r_pay_cnt + 16'd1;
          if (r_pay_cnt == r_desc.len - 16'd1) w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // The RAM read address runs one step ahead when a payload byte is taken,
  // so r_mem_q always shows the byte at the current fetch pointer.
  assign w_fetch_nxt = r_fetch_ptr + PW'(w_fetch_inc);

  // ---------------- RAMs (no reset) ----------------
  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_wr_ptr[BUF_AW-1:0]] <= bus.in_data;
    r_mem_q <= r_mem[w_fetch_nxt[BUF_AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (w_push) r_dfifo[r_dwp[1:0]] <= w_push_desc;
  end

  // ---------------- state registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_pkt_start <= '0;
      r_cur_len   <= '0;
      r_prev      <= '0;
      r_discard   <= 1'b0;
      r_seq       <= '0;
      r_fid       <= '0;
      r_drop      <= 1'b0;
      r_dwp       <= '0;
      r_drp       <= '0;
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_desc      <= '0;
      r_pay_cnt   <= '0;
      r_fetch_ptr <= '0;
      r_rel_ptr   <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sop   <= 1'b0;
      r_out_eop   <= 1'b0;
      r_out_pay   <= 1'b0;
    end else begin
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_pkt_start <= w_pkt_start_nxt;
      r_cur_len   <= w_cur_len_nxt;
      r_prev      <= w_prev_nxt;
      r_discard   <= w_discard_nxt;
      r_seq       <= w_seq_nxt;
      r_fid       <= w_fid_nxt;
      r_drop      <= w_drop_nxt;
      if (w_push) r_dwp <= r_dwp + 3'd1;
      if (w_pop)  r_drp <= r_drp + 3'd1;
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_desc      <= w_desc_nxt;
      r_pay_cnt   <= w_pay_cnt_nxt;
      r_fetch_ptr <= w_fetch_nxt;
      if (w_release) r_rel_ptr <= r_rel_ptr + P_ONE;
      r_out_valid <= w_out_valid_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_sop   <= w_out_sop_nxt;
      r_out_eop   <= w_out_eop_nxt;
      r_out_pay   <= w_out_pay_nxt;
    end
  end

  assign bus.out_valid  = r_out_valid;
  assign bus.out_data   = r_out_data;
  assign bus.out_sop    = r_out_sop;
  assign bus.out_eop    = r_out_eop;
  assign bus.drop_pulse = r_drop;
  assign bus.frame_id   = r_fid;
endmodule
